// File: rtl/mux_scan.sv
// rtl/mux_scan.sv - registered N-channel mux with manual select and auto-scan sequencing
module mux_scan #(
  parameter int N    = 4,
  parameter int W    = 1,
  parameter int HOLD = 1,
  localparam int SELW = (N > 2) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N*W-1:0]    a,
  input  logic [SELW-1:0]   s,
  input  logic              mode,
  input  logic              en,
  output logic [W-1:0]      y,
  output logic [SELW-1:0]   y_sel,
  output logic              y_valid,
  output logic              wrap
);

  localparam int DW = (HOLD > 2) ? $clog2(HOLD) : 1;
  localparam logic [SELW-1:0] SEL_LAST  = SELW'(N - 1);
  localparam logic [DW-1:0]   DWELL_END = DW'(HOLD - 1);

  logic [SELW-1:0] sel_cnt;
  logic [DW-1:0]   dwell_cnt;
  logic [W-1:0]    man_data;
  logic [W-1:0]    scan_data;
  logic            s_ok;
  logic            sel_last;
  logic            dwell_last;

  // Loop-based decode keeps out-of-range selects from indexing past a.
  always_comb begin
    man_data  = '0;
    scan_data = '0;
    s_ok      = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (s == SELW'(i)) begin
        man_data = a[i*W +: W];
        s_ok     = 1'b1;
      end
      if (sel_cnt == SELW'(i)) scan_data = a[i*W +: W];
    end
  end

  assign sel_last   = (sel_cnt == SEL_LAST);
  assign dwell_last = (dwell_cnt == DWELL_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y         <= '0;
      y_sel     <= '0;
      y_valid   <= 1'b0;
      wrap      <= 1'b0;
      sel_cnt   <= '0;
      dwell_cnt <= '0;
    end else begin
      // Manual mode parks the scan position so the next scan starts at channel 0.
      if (!mode) begin
        sel_cnt   <= '0;
        dwell_cnt <= '0;
      end
      if (!en) begin
        y_valid <= 1'b0;
        wrap    <= 1'b0;
      end else if (!mode) begin
        y       <= s_ok ? man_data : '0;
        y_sel   <= s;
        y_valid <= s_ok;
        wrap    <= 1'b0;
      end else begin
        y       <= scan_data;
        y_sel   <= sel_cnt;
        y_valid <= 1'b1;
        wrap    <= sel_last && dwell_last;
        if (dwell_last) begin
          dwell_cnt <= '0;
          sel_cnt   <= sel_last ? '0 : sel_cnt + SELW'(1);
        end else begin
          dwell_cnt <= dwell_cnt + DW'(1);
        end
      end
    end
  end

endmodule

// File: doc/mux_scan.md
# mux_scan

Parametrised, registered N-channel, W-bit multiplexer with two modes: manual select and auto-scan. In auto-scan, an internal counter steps through the channels with a programmable dwell. It generalises the team's combinational 4:1 mux into a clocked channel sequencer for time-division sampling of parallel inputs, and it reports which channel is on the output. The output is one register stage behind the inputs.

## Interface
- N, default 4: channel count, 2..16.
- W, default 1: data width per channel, ≥1.
- HOLD, default 1: cycles each channel is held in scan mode, ≥1.
- SELW, derived (localparam): max(1, clog2(N)).

Clock and reset are fixed: one clock, asynchronous active-low reset.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- a  input  N*W  packed channels; channel i is a[i*W +: W].
- s  input  SELW  manual select, used only when mode=0.
- mode  input  1  0 = manual, 1 = auto-scan.
- en  input  1  update enable.
- y  output  W  registered selected data.
- y_sel  output  SELW  channel index that produced y.
- y_valid  output  1  y/y_sel hold a valid sample taken on the last edge.
- wrap  output  1  one-cycle pulse on the sample that ends a full scan.

## Operation
- Reset (rst_n=0, asynchronous): y=0, y_sel=0, y_valid=0, wrap=0, internal sel_cnt=0, dwell_cnt=0. These values hold while rst_n is low.
- en=0 on an edge:
  - y, y_sel, sel_cnt and dwell_cnt hold.
  - y_valid←0, wrap←0.
- Manual mode (mode=0, en=1), s<N:
  - y←a[s], y_sel←s, y_valid←1, wrap←0.
- Manual mode (mode=0, en=1), s≥N (possible only for non-power-of-2 N):
  - y←0, y_sel←s, y_valid←0.
- Manual mode, any en: sel_cnt←0 and dwell_cnt←0, so scan always starts at channel 0.
- Scan mode (mode=1, en=1):
  - y←a[sel_cnt], y_sel←sel_cnt, y_valid←1.
  - If dwell_cnt==HOLD−1: dwell_cnt←0, and sel_cnt←(sel_cnt==N−1) ? 0 : sel_cnt+1.
  - Otherwise: dwell_cnt←dwell_cnt+1.
  - wrap←1 exactly when sel_cnt==N−1 and dwell_cnt==HOLD−1; otherwise wrap←0.
- Mode change takes effect on the same edge it is sampled. Scan→manual: that edge uses s. Manual→scan: that edge outputs channel 0.
- s is ignored in scan mode. a is sampled only on enabled edges.
- Out-of-range s does not disturb sel_cnt or dwell_cnt.

## Timing
- Latency is 1 cycle: values on a/s/mode/en at edge k appear on y/y_sel/y_valid/wrap after edge k.
- Manual mode gives full throughput: a new s every cycle gives a new y every cycle.
- One scan period is N·HOLD enabled cycles. Disabled cycles stretch it without losing position.
- wrap is coincident with the last sample of channel N−1. It is never asserted for two consecutive cycles unless N·HOLD=1 (impossible because N≥2).
- Reset mid-scan: the next enabled scan edge after rst_n rises samples channel 0 with dwell restarted.
- Asynchronous assert is immediate. Deassert is sampled at the clock; the first active edge is the first rising edge with rst_n=1.

## Test plan
- Reset: hold rst_n=0 with random a/s/mode/en, and also assert it between clock edges. Required: y=0, y_sel=0, y_valid=0, wrap=0 immediately and throughout.
- Manual sweep, N=4, W=1, a=4'b1100, mode=0, en=1:
  - Stimulus: s=0,1,2,3 on successive edges.
  - Required: y=0,0,1,1 and y_sel=0,1,2,3, each one cycle after its s.
  - Required: y_valid=1 from the first edge on; wrap=0 throughout.
- Scan, N=4, W=1, HOLD=1, a=4'b1010, mode=1, en=1 for 8 cycles:
  - Required: y=0,1,0,1,0,1,0,1 and y_sel=0,1,2,3,0,1,2,3.
  - Required: wrap=1 only on the y_sel=3 samples.
- Scan with dwell, N=3, W=8, HOLD=2, channels {8'hA0, 8'hB1, 8'hC2}:
  - Required: y=A0,A0,B1,B1,C2,C2,A0…
  - Required: wrap=1 on the second C2 sample only.
- Enable gap and bad select:
  - In scan with HOLD=1, N=4, drop en for 3 cycles after y_sel=1. Required: y/y_sel freeze, y_valid=0, then resume at y_sel=2.
  - N=3, manual, s=3. Required: y=0, y_valid=0, y_sel=3.
- Mode switch and mid-scan reset:
  - Switch to manual with s=2 while scan sits at y_sel=1. Required: next y_sel=2.
  - Return to scan. Required: next y_sel=0.
  - Assert rst_n low while y_sel=2 in scan, then release. Required: first enabled sample has y_sel=0.
